nba_event_scheduler: RTL and testbench

Event scheduler for the simulation-scheduling test designs. Requesters post update events, each a data word plus a relative delay in cycles. The block holds the events in a slot array and counts each one down. It releases matured events one at a time through a registered valid/ready output, in deterministic order. It models the deferred-update region that the blocking/nonblocking scheduling testcases exercise, and it sits between the stimulus generators and the register-update datapath.

---
 rtl/nba_event_scheduler.sv | 143 ++++++++++++++
 tb/tb_nba_event_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nba_event_scheduler.sv
// rtl/nba_event_scheduler.sv - slot-array event scheduler with delayed, ordered release
//
// Purpose: requesters post (data, delay) events into a slot array; each slot
// counts down to zero and matured events leave one at a time through a
// registered valid/ready output in slot-index order.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   post_valid/post_ready event offer handshake
//   post_delay, post_data relative delay in cycles and payload of the offered event
//   fire_valid/fire_ready output handshake for a matured event
//   fire_data             payload of the event being fired
//   flush                 synchronous clear of all slots and the output register
//   pending               occupied slots plus output register (0..DEPTH+1)
//   late_cnt              stall counter, present only when SCHED_LATE_CNT_EN is defined
//
// Optional feature macro: SCHED_LATE_CNT_EN

module nba_event_scheduler #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int DELAY_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     post_valid,
    output logic                     post_ready,
    input  logic [DELAY_W-1:0]       post_delay,
    input  logic [DATA_W-1:0]        post_data,
    output logic                     fire_valid,
    input  logic                     fire_ready,
    output logic [DATA_W-1:0]        fire_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   pending
`ifdef SCHED_LATE_CNT_EN
    ,
    output logic [15:0]              late_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]   occ;
    logic [DELAY_W-1:0] cnt  [DEPTH];
    logic [DATA_W-1:0]  data [DEPTH];

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               mat_found;
    logic [IDX_W-1:0]   mat_idx;

    logic               accept;
    logic               take;
    logic               load;

    // Lowest-index free slot and lowest-index matured slot.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        mat_found  = 1'b0;
        mat_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!occ[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (occ[i] && (cnt[i] == '0) && !mat_found) begin
                mat_found = 1'b1;
                mat_idx   = IDX_W'(i);
            end
        end
    end

    // Readiness depends only on current occupancy, so a slot emptied by a
    // load this cycle becomes visible as free one cycle later.
    assign post_ready = free_found;
    assign accept     = post_valid && post_ready && !flush;
    assign take       = fire_valid && fire_ready;
    assign load       = mat_found && (!fire_valid || take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= '0;
            fire_valid <= 1'b0;
            fire_data  <= '0;
            pending    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i]  <= '0;
                data[i] <= '0;
            end
        end else if (flush) begin
            occ        <= '0;
            fire_valid <= 1'b0;
            pending    <= '0;
        end else begin
            // Countdown saturates at zero; matured slots simply wait.
            for (int i = 0; i < DEPTH; i++) begin
                if (occ[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - DELAY_W'(1);
                end
            end

            if (load) begin
                occ[mat_idx] <= 1'b0;
                fire_valid   <= 1'b1;
                fire_data    <= data[mat_idx];
            end else if (take) begin
                fire_valid   <= 1'b0;
            end

            // The accept slot is currently free, so it never collides with
            // the load slot or the countdown above.
            if (accept) begin
                occ[free_idx]  <= 1'b1;
                cnt[free_idx]  <= post_delay;
                data[free_idx] <= post_data;
            end

            // A load moves an event from a slot into the output register,
            // leaving the total unchanged.
            pending <= pending + CNT_W'(accept) - CNT_W'(take);
        end
    end

`ifdef SCHED_LATE_CNT_EN
    logic late_evt;

    // The output register being full is exactly fire_valid.
    assign late_evt = fire_valid && (!fire_ready || mat_found);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            late_cnt <= '0;
        end else if (flush) begin
            late_cnt <= '0;
        end else if (late_evt && (late_cnt != 16'hFFFF)) begin
            late_cnt <= late_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nba_event_scheduler.sv
// tb/tb_nba_event_scheduler.sv - directed self-checking bench for nba_event_scheduler

module tb_nba_event_scheduler;

    logic       clk;
    logic       rst_n;
    logic       post_valid;
    logic       post_ready;
    logic [3:0] post_delay;
    logic [7:0] post_data;
    logic       fire_valid;
    logic       fire_ready;
    logic [7:0] fire_data;
    logic       flush;
    logic [3:0] pending;
`ifdef SCHED_LATE_CNT_EN
    logic [15:0] late_cnt;
`endif

    int checks;
    int failures;

    nba_event_scheduler #(
        .DATA_W  (8),
        .DEPTH   (8),
        .DELAY_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .post_valid (post_valid),
        .post_ready (post_ready),
        .post_delay (post_delay),
        .post_data  (post_data),
        .fire_valid (fire_valid),
        .fire_ready (fire_ready),
        .fire_data  (fire_data),
        .flush      (flush),
        .pending    (pending)
`ifdef SCHED_LATE_CNT_EN
        ,
        .late_cnt   (late_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        post_valid = 1'b0;
        post_delay = '0;
        post_data  = '0;
        fire_ready = 1'b0;
        flush      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (fire_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_fire_valid cycle %0d: got %b want 0", k, fire_valid);
            end
            checks++;
            if (pending !== 4'd0) begin
                failures++;
                $display("FAIL reset_pending cycle %0d: got %0d want 0", k, pending);
            end
            checks++;
            if (post_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_post_ready cycle %0d: got %b want 1", k, post_ready);
            end
        end
`ifdef SCHED_LATE_CNT_EN
        checks++;
        if (late_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_late_cnt: got %0d want 0", late_cnt);
        end
`endif
    endtask

    task automatic test_single();
        fire_ready = 1'b1;
        post_valid = 1'b1;
        post_data  = 8'hA5;
        post_delay = 4'd0;
        step();                     // edge E: accept
        post_valid = 1'b0;
        checks++;
        if (fire_valid !== 1'b0 || pending !== 4'd1) begin
            failures++;
            $display("FAIL single_after_accept: valid=%b pending=%0d want valid=0 pending=1", fire_valid, pending);
        end
        step();                     // edge E+1: load
        checks++;
        if (fire_valid !== 1'b1 || fire_data !== 8'hA5) begin
            failures++;
            $display("FAIL single_fire: valid=%b data=%h want valid=1 data=a5", fire_valid, fire_data);
        end
        checks++;
        if (pending !== 4'd1) begin
            failures++;
            $display("FAIL single_pending_hold: got %0d want 1", pending);
        end
        step();                     // edge E+2: taken
        checks++;
        if (fire_valid !== 1'b0 || pending !== 4'd0) begin
            failures++;
            $display("FAIL single_drain: valid=%b pending=%0d want valid=0 pending=0", fire_valid, pending);
        end
    endtask

    task automatic test_order();
        logic [7:0] p_data  [3];
        logic [3:0] p_delay [3];
        logic       e_valid [9];
        logic [7:0] e_data  [9];
        p_data  = '{8'h11, 8'h22, 8'h33};
        p_delay = '{4'd5, 4'd1, 4'd1};
        // Expected output after edges E..E+8.
        e_valid = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        e_data  = '{8'h00, 8'h00, 8'h00, 8'h22, 8'h33, 8'h00, 8'h11, 8'h00, 8'h00};
        fire_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 3) begin
                post_valid = 1'b1;
                post_data  = p_data[k];
                post_delay = p_delay[k];
            end else begin
                post_valid = 1'b0;
            end
            step();
            checks++;
            if (fire_valid !== e_valid[k]) begin
                failures++;
                $display("FAIL order_valid E+%0d: got %b want %b", k, fire_valid, e_valid[k]);
            end else if (e_valid[k] && fire_data !== e_data[k]) begin
                failures++;
                $display("FAIL order_data E+%0d: got %h want %h", k, fire_data, e_data[k]);
            end
        end
        post_valid = 1'b0;
    endtask

    task automatic test_fill();
        logic [7:0] e_order [9];
        // Event 0 sits in the output register; event 1 lands in slot 1
        // because slot 0 is freed by a load only one edge later, so event 2
        // takes slot 0 and leaves ahead of event 1.
        e_order = '{8'h10, 8'h12, 8'h11, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        fire_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            post_valid = 1'b1;
            post_data  = 8'h10 + 8'(i);
            post_delay = 4'd0;
            checks++;
            if (post_ready !== 1'b1) begin
                failures++;
                $display("FAIL fill_ready_before_%0d: got %b want 1", i, post_ready);
            end
            step();
        end
        post_valid = 1'b0;
        checks++;
        if (post_ready !== 1'b0 || pending !== 4'd9) begin
            failures++;
            $display("FAIL fill_full: ready=%b pending=%0d want ready=0 pending=9", post_ready, pending);
        end
        step();
        step();
        checks++;
        if (fire_valid !== 1'b1 || fire_data !== 8'h10) begin
            failures++;
            $display("FAIL fill_hold: valid=%b data=%h want valid=1 data=10", fire_valid, fire_data);
        end
        fire_ready = 1'b1;
        for (int j = 1; j < 9; j++) begin
            step();
            checks++;
            if (fire_valid !== 1'b1 || fire_data !== e_order[j]) begin
                failures++;
                $display("FAIL fill_fire_%0d: valid=%b data=%h want valid=1 data=%h", j, fire_valid, fire_data, e_order[j]);
            end
            if (j == 1) begin
                checks++;
                if (post_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL fill_ready_rise: got %b want 1", post_ready);
                end
            end
        end
        step();
        checks++;
        if (fire_valid !== 1'b0 || pending !== 4'd0) begin
            failures++;
            $display("FAIL fill_drain: valid=%b pending=%0d want valid=0 pending=0", fire_valid, pending);
        end
    endtask

    task automatic test_flush();
        fire_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            post_valid = 1'b1;
            post_data  = 8'h40 + 8'(i);
            post_delay = 4'd0;
            step();
        end
        post_valid = 1'b0;
        checks++;
        if (fire_valid !== 1'b1 || pending !== 4'd4) begin
            failures++;
            $display("FAIL flush_setup: valid=%b pending=%0d want valid=1 pending=4", fire_valid, pending);
        end
        flush      = 1'b1;
        post_valid = 1'b1;
        post_data  = 8'hEE;
        post_delay = 4'd0;
        step();
        flush      = 1'b0;
        post_valid = 1'b0;
        checks++;
        if (fire_valid !== 1'b0 || pending !== 4'd0 || post_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear: valid=%b pending=%0d ready=%b want 0/0/1", fire_valid, pending, post_ready);
        end
        fire_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (fire_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_fire cycle %0d: valid=%b data=%h want valid=0", k, fire_valid, fire_data);
            end
        end
    endtask

`ifdef SCHED_LATE_CNT_EN
    task automatic test_late_cnt();
        checks++;
        if (late_cnt !== 16'd0) begin
            failures++;
            $display("FAIL late_start: got %0d want 0", late_cnt);
        end
        fire_ready = 1'b0;
        post_valid = 1'b1;
        post_data  = 8'h77;
        post_delay = 4'd0;
        step();                     // accept
        post_valid = 1'b0;
        step();                     // load, fire_valid now 1
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (late_cnt !== 16'd20) begin
            failures++;
            $display("FAIL late_count: got %0d want 20", late_cnt);
        end
    endtask
`endif

    task automatic test_async_reset();
        fire_ready = 1'b0;
        post_valid = 1'b1;
        post_data  = 8'h5A;
        post_delay = 4'd0;
        step();
        post_valid = 1'b0;
        step();
        step();
        checks++;
        if (fire_valid !== 1'b1 || fire_data !== 8'h5A) begin
            failures++;
            $display("FAIL areset_setup: valid=%b data=%h want valid=1 data=5a", fire_valid, fire_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fire_valid !== 1'b0 || pending !== 4'd0 || fire_data !== 8'h00) begin
            failures++;
            $display("FAIL areset_clear: valid=%b pending=%0d data=%h want 0/0/00", fire_valid, pending, fire_data);
        end
`ifdef SCHED_LATE_CNT_EN
        checks++;
        if (late_cnt !== 16'd0) begin
            failures++;
            $display("FAIL areset_late: got %0d want 0", late_cnt);
        end
`endif
        step();
        rst_n      = 1'b1;
        fire_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (fire_valid !== 1'b0 || pending !== 4'd0) begin
            failures++;
            $display("FAIL areset_lost: valid=%b pending=%0d want 0/0", fire_valid, pending);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_order();
        test_fill();
        test_flush();
`ifdef SCHED_LATE_CNT_EN
        test_late_cnt();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
